// File: rtl/key_entry.sv
// rtl/key_entry.sv - four-digit keypad entry collector with timeout and failure lockout.
// Feeds user_key/validate_en to the validation stage and reports its verdict as key_ok/key_bad.
module key_entry #(
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000,
  parameter int unsigned LOCKOUT_CYCLES = 1_500_000_000,
  parameter int unsigned MAX_FAILS      = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  digit,
  input  logic        digit_valid,
  input  logic        enter,
  input  logic        clear,
  input  logic        correct_signal,
  output logic [15:0] user_key,
  output logic        validate_en,
  output logic [2:0]  digit_count,
  output logic        key_ok,
  output logic        key_bad,
  output logic [2:0]  fail_count,
  output logic        lockout
);

  localparam int unsigned LIMIT = (TIMEOUT_CYCLES > LOCKOUT_CYCLES) ? TIMEOUT_CYCLES : LOCKOUT_CYCLES;
  localparam int TW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] LOCKOUT_LAST = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [2:0]    FAIL_MAX     = 3'(MAX_FAILS);

  typedef enum logic [2:0] {
    S_IDLE, S_ENTRY, S_FULL, S_SUBMIT, S_CHECK, S_LOCKOUT
  } state_t;

  state_t        state, state_next;
  logic [TW-1:0] timer, timer_next;
  logic [15:0]   key_next;
  logic [2:0]    count_next, fail_next, fail_inc;
  logic          ok_next, bad_next, fail_event;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      timer       <= '0;
      user_key    <= '0;
      digit_count <= '0;
      fail_count  <= '0;
      validate_en <= 1'b0;
      key_ok      <= 1'b0;
      key_bad     <= 1'b0;
      lockout     <= 1'b0;
    end else begin
      state       <= state_next;
      timer       <= timer_next;
      user_key    <= key_next;
      digit_count <= count_next;
      fail_count  <= fail_next;
      validate_en <= (state_next == S_SUBMIT);
      key_ok      <= ok_next;
      key_bad     <= bad_next;
      lockout     <= (state_next == S_LOCKOUT);
    end
  end

  assign fail_inc = (fail_count >= FAIL_MAX) ? fail_count : fail_count + 3'd1;

  always_comb begin
    state_next = state;
    timer_next = timer;
    key_next   = user_key;
    count_next = digit_count;
    fail_next  = fail_count;
    ok_next    = 1'b0;
    bad_next   = 1'b0;
    fail_event = 1'b0;

    case (state)
      S_IDLE: begin
        if (digit_valid) begin
          key_next   = {user_key[11:0], digit};
          count_next = 3'd1;
          state_next = S_ENTRY;
        end
      end
      S_ENTRY, S_FULL: begin
        // Accepted inputs win over a timeout landing in the same cycle.
        if (clear) begin
          state_next = S_IDLE;
        end else if (enter) begin
          if (state == S_FULL) state_next = S_SUBMIT;
          else                 fail_event = 1'b1;
        end else if (digit_valid && state == S_ENTRY) begin
          key_next   = {user_key[11:0], digit};
          count_next = digit_count + 3'd1;
          timer_next = '0;
          if (digit_count == 3'd3) state_next = S_FULL;
        end else if (timer == TIMEOUT_LAST) begin
          state_next = S_IDLE;
        end else begin
          timer_next = timer + TW'(1);
        end
      end
      S_SUBMIT: state_next = S_CHECK;
      S_CHECK: begin
        if (correct_signal) begin
          ok_next    = 1'b1;
          fail_next  = '0;
          state_next = S_IDLE;
        end else begin
          fail_event = 1'b1;
        end
      end
      S_LOCKOUT: begin
        if (timer == LOCKOUT_LAST) begin
          fail_next  = '0;
          state_next = S_IDLE;
        end else begin
          timer_next = timer + TW'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase

    if (fail_event) begin
      bad_next   = 1'b1;
      fail_next  = fail_inc;
      state_next = (fail_inc == FAIL_MAX) ? S_LOCKOUT : S_IDLE;
    end

    if (state_next != state) timer_next = '0;

    // A stale entry never survives into IDLE or a lockout.
    if (state_next == S_IDLE || state_next == S_LOCKOUT) begin
      key_next   = '0;
      count_next = '0;
    end
  end

endmodule
